// File: rtl/input_debounce_pkg.sv
// input_debounce_pkg
//   Shared constants and helpers for the input_debounce block.
//   - DEF_WIDTH / DEF_SYNC_STAGES / DEF_DEBOUNCE_LEN : default parameter values
//   - cnt_width() : width of the per-channel stability counter
package input_debounce_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_LEN = 16;

  // The counter only ever reaches DEBOUNCE_LEN-1, but sizing for
  // DEBOUNCE_LEN+1 values keeps the terminal compare unambiguous.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/input_debounce_bit.sv
// debounce_bit
//   One debounce channel: synchronizer chain, stability counter and
//   registered debounced level with one-cycle edge pulses.
//   Ports:
//     clk_i    : clock, rising edge active
//     rst_ni   : asynchronous active-low reset
//     ena_i    : enable; low freezes counter and debounced level
//     raw_i    : asynchronous pad input
//     db_o     : debounced level
//     rise_o   : one-cycle pulse on db_o 0->1
//     fall_o   : one-cycle pulse on db_o 1->0
module debounce_bit
  import input_debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_LEN = DEF_DEBOUNCE_LEN
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ena_i,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_width(DEBOUNCE_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchronizer keeps sampling regardless of ena.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Counter counts consecutive cycles of disagreement between the
  // synchronized input and the accepted level. Reaching the last count
  // while still disagreeing accepts the new level; the counter therefore
  // never passes CNT_LAST.
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (ena_i) begin
      if (sync_bit == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        db_d   = sync_bit;
        rise_d = sync_bit;
        fall_d = ~sync_bit;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/input_debounce.sv
// input_debounce
//   WIDTH independent debounce channels plus an all-high summary.
//   Ports:
//     clk      : clock, rising edge active
//     rst_n    : asynchronous active-low reset
//     ena      : enable; low freezes debounce state, syncs keep sampling
//     raw_in   : asynchronous pad inputs
//     db_out   : debounced registered levels
//     rise     : one-cycle pulse per bit on db_out 0->1
//     fall     : one-cycle pulse per bit on db_out 1->0
//     all_high : combinational AND of db_out
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_LEN = DEF_DEBOUNCE_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             all_high
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_LEN(DEBOUNCE_LEN)
    ) u_bit (
      .clk_i (clk),
      .rst_ni(rst_n),
      .ena_i (ena),
      .raw_i (raw_in[g]),
      .db_o  (db_out[g]),
      .rise_o(rise[g]),
      .fall_o(fall[g])
    );
  end

  // Reset clears db_out, so this is 0 during reset as well.
  assign all_high = &db_out;

endmodule

// File: tb/tb_input_debounce.sv
module tb_input_debounce;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] raw_in;
  logic [7:0] db_out;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       all_high;

  int total;
  int bad;

  typedef struct {
    logic [7:0] raw;
    logic       ena;
    int         n;
    bit         each;
    logic [7:0] db;
    logic [7:0] rs;
    logic [7:0] fl;
    logic       ah;
    string      name;
  } vec_t;

  vec_t tbl[20];

  input_debounce #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .DEBOUNCE_LEN(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .raw_in  (raw_in),
    .db_out  (db_out),
    .rise    (rise),
    .fall    (fall),
    .all_high(all_high)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] d, input logic [7:0] r,
                         input logic [7:0] f, input logic a);
    chk8({nm, ".db"}, db_out, d);
    chk8({nm, ".rise"}, rise, r);
    chk8({nm, ".fall"}, fall, f);
    chk8({nm, ".all_high"}, {7'd0, all_high}, {7'd0, a});
  endtask

  // One rising edge, then settle before sampling/driving.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input vec_t v);
    raw_in = v.raw;
    ena    = v.ena;
    for (int i = 0; i < v.n; i++) begin
      cyc();
      if (v.each || i == v.n - 1) chk_all(v.name, v.db, v.rs, v.fl, v.ah);
    end
  endtask

  initial begin
    int pulses;
    int at;
    vec_t v;

    total = 0;
    bad   = 0;

    tbl[0]  = '{8'hFF, 1'b1, 17, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, "rel_wait"};
    tbl[1]  = '{8'hFF, 1'b1,  1, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1, "rel_rise"};
    tbl[2]  = '{8'hFF, 1'b1,  1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, "rise_clr"};
    tbl[3]  = '{8'hF7, 1'b1, 15, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, "glitch_lo"};
    tbl[4]  = '{8'hFF, 1'b1, 10, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, "glitch_back"};
    tbl[5]  = '{8'hF7, 1'b1, 17, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, "hold_lo_wait"};
    tbl[6]  = '{8'hF7, 1'b1,  1, 1'b1, 8'hF7, 8'h00, 8'h08, 1'b0, "hold_lo_fall"};
    tbl[7]  = '{8'hF7, 1'b1,  1, 1'b1, 8'hF7, 8'h00, 8'h00, 1'b0, "fall_clr"};
    tbl[8]  = '{8'hFF, 1'b1, 12, 1'b1, 8'hF7, 8'h00, 8'h00, 1'b0, "cnt10"};
    tbl[9]  = '{8'hFF, 1'b0, 50, 1'b1, 8'hF7, 8'h00, 8'h00, 1'b0, "ena_frozen"};
    tbl[10] = '{8'hFF, 1'b1,  5, 1'b1, 8'hF7, 8'h00, 8'h00, 1'b0, "ena_resume"};
    tbl[11] = '{8'hFF, 1'b1,  1, 1'b1, 8'hFF, 8'h08, 8'h00, 1'b1, "ena_rise"};
    tbl[12] = '{8'hFF, 1'b1,  1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, "rise_clr2"};
    tbl[13] = '{8'h5A, 1'b1, 17, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, "multi_wait1"};
    tbl[14] = '{8'h5A, 1'b1,  1, 1'b1, 8'h5A, 8'h00, 8'hA5, 1'b0, "multi_fall"};
    tbl[15] = '{8'hA5, 1'b1, 17, 1'b1, 8'h5A, 8'h00, 8'h00, 1'b0, "multi_wait2"};
    tbl[16] = '{8'hA5, 1'b1,  1, 1'b1, 8'hA5, 8'hA5, 8'h5A, 1'b0, "multi_swap"};
    tbl[17] = '{8'hFF, 1'b1, 17, 1'b1, 8'hA5, 8'h00, 8'h00, 1'b0, "multi_wait3"};
    tbl[18] = '{8'hFF, 1'b1,  1, 1'b1, 8'hFF, 8'h5A, 8'h00, 1'b1, "multi_rise"};
    tbl[19] = '{8'hFF, 1'b1,  1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, "multi_clr"};

    // Reset with inputs already high.
    rst_n  = 1'b0;
    ena    = 1'b1;
    raw_in = 8'hFF;
    repeat (3) cyc();
    chk_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);

    // Release just after edge 0, so edge 1 is the first sample.
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) run(tbl[i]);

    // Bring channel 0 low, then bounce it.
    v = '{8'hFE, 1'b1, 18, 1'b0, 8'hFE, 8'h00, 8'h01, 1'b0, "ch0_low"};
    run(v);
    v = '{8'hFE, 1'b1, 1, 1'b1, 8'hFE, 8'h00, 8'h00, 1'b0, "ch0_low_clr"};
    run(v);

    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      raw_in = {7'h7F, ((i / 3) % 2) == 0};
      cyc();
      if (rise[0]) pulses++;
    end
    chk_int("bounce_no_rise", pulses, 0);
    chk8("bounce_db", db_out, 8'hFE);

    raw_in = 8'hFF;
    pulses = 0;
    at     = -1;
    for (int n = 1; n <= 30; n++) begin
      cyc();
      if (rise[0]) begin
        pulses++;
        at = n;
      end
    end
    chk_int("settle_rise_count", pulses, 1);
    chk_int("settle_rise_edge", at, 18);
    chk8("settle_db", db_out, 8'hFF);

    // Asynchronous reset in the middle of a count.
    v = '{8'h00, 1'b1, 8, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, "pre_areset"};
    run(v);
    #2 rst_n = 1'b0;
    #1;
    chk_all("areset", 8'h00, 8'h00, 8'h00, 1'b0);

    // Partial count must be gone after release.
    raw_in = 8'hFF;
    @(posedge clk);
    #1 rst_n = 1'b1;
    v = '{8'hFF, 1'b1, 17, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, "rel2_wait"};
    run(v);
    v = '{8'hFF, 1'b1, 1, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1, "rel2_rise"};
    run(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 Parameter WIDTH, default 8, number of independent input channels.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop depth per channel, legal range 2..4.
REQ-003 Parameter DEBOUNCE_LEN, default 16, consecutive stable synchronized cycles required to accept a new level, legal range 2..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset; assertion clears state immediately, release is synchronous to clk.
REQ-006 ena  input  1  design enable; low freezes debounce state.
REQ-007 raw_in  input  WIDTH  asynchronous pad inputs, no timing relation to clk.
REQ-008 db_out  output  WIDTH  debounced, registered level per channel.
REQ-009 rise  output  WIDTH  one-cycle registered pulse when db_out bit goes 0->1.
REQ-010 fall  output  WIDTH  one-cycle registered pulse when db_out bit goes 1->0.
REQ-011 all_high  output  1  combinational AND of all db_out bits; feeds the downstream AND/shift pipeline directly.

Function
REQ-012 Each raw_in bit SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync bit) is used by debounce logic.
REQ-013 Each channel SHALL own a counter of width clog2(DEBOUNCE_LEN+1); counter clears on any cycle where sync bit equals db_out bit.
REQ-014 When sync bit differs from db_out bit and ena is high, counter SHALL increment by one per cycle.
REQ-015 On the edge where counter equals DEBOUNCE_LEN-1 and sync still differs, db_out bit SHALL take the sync value and counter SHALL clear.
REQ-016 Latency: a raw_in transition held stable SHALL appear on db_out exactly SYNC_STAGES+DEBOUNCE_LEN rising edges after first being sampled.
REQ-017 Any excursion of the sync bit lasting fewer than DEBOUNCE_LEN cycles SHALL leave db_out unchanged and produce no rise/fall pulse.
REQ-018 rise/fall bits SHALL assert in the same cycle db_out changes, for exactly one cycle; rise and fall of one channel never assert together.
REQ-019 Channels SHALL be fully independent; simultaneous qualifying changes on several channels update in the same cycle.
REQ-020 With ena low, counters and db_out SHALL hold, rise/fall SHALL be 0; synchronizers keep sampling.
REQ-021 When ena returns high, counting SHALL resume from the held counter value.
REQ-022 Counter SHALL never exceed DEBOUNCE_LEN-1 (no wrap-around).

Reset
REQ-023 On rst_n low, all synchronizer flops, counters, db_out, rise and fall SHALL be 0 asynchronously, without a clock edge.
REQ-024 all_high SHALL therefore be 0 during reset.
REQ-025 After release, a raw_in bit already high SHALL be treated as a normal 0->1 transition (rise pulse after full latency).
REQ-026 Reset asserted mid-count SHALL discard the partial count.

Structure
REQ-027 Shared package input_debounce_pkg SHALL hold default WIDTH, SYNC_STAGES and DEBOUNCE_LEN constants and the counter-width function.
REQ-028 Sub-module debounce_bit (one synchronizer chain, one counter, one db/rise/fall bit) SHALL be instantiated WIDTH times by a generate loop.
REQ-029 Top level contains only the generate loop, the all_high reduction and port wiring.

Verification
REQ-030 raw_in=8'hFF held through reset, rst_n released at edge 0 -> db_out=8'h00 through edge 17, db_out=8'hFF, rise=8'hFF, all_high=1 at edge 18; rise=0 at edge 19.
REQ-031 From db_out=8'hFF, raw_in[3] low for 15 cycles then high -> db_out stays 8'hFF, fall=0 throughout.
REQ-032 raw_in[3] low and held -> db_out=8'hF7, fall=8'h08 for one cycle, all_high=0, 18 edges after first sample.
REQ-033 ena low after 10 counting cycles for 50 cycles -> no change; ena high -> db_out changes after 6 further cycles.
REQ-034 rst_n pulsed low mid-count without a clk edge -> db_out, rise, fall, all_high read 0 immediately.
REQ-035 raw_in[0] toggling every 3 cycles for 40 cycles then held high -> exactly one rise[0] pulse, 18 edges after the final transition.
